// File: rtl/sm_pkg.sv
// Shared types and defaults for the sign-magnitude sorter.
package sm_pkg;

  localparam int unsigned N_DEF = 8;
  localparam int unsigned M_DEF = 4;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    OUT
  } sm_state_t;

  // Index counter width for an M-entry array, never below one bit.
  function automatic int unsigned idx_width(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/comparator.sv
// Sign-magnitude comparator: ge_o = (a_i >= b_i), with +0 ranked above -0.
module comparator #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         ge_o
);

  localparam int unsigned MW = N - 1;

  logic          sign_a;
  logic          sign_b;
  logic [MW-1:0] mag_a;
  logic [MW-1:0] mag_b;

  assign sign_a = a_i[N-1];
  assign sign_b = b_i[N-1];
  assign mag_a  = a_i[MW-1:0];
  assign mag_b  = b_i[MW-1:0];

  // Among negatives a smaller magnitude is the larger value.
  always_comb begin
    ge_o = 1'b0;
    if (sign_a != sign_b) begin
      ge_o = ~sign_a;
    end else if (!sign_a) begin
      ge_o = (mag_a >= mag_b);
    end else begin
      ge_o = (mag_a <= mag_b);
    end
  end

endmodule

// File: rtl/sm_sorter.sv
// Batch sorter: loads M sign-magnitude values, bubble-sorts them descending
// through one shared comparator, then streams them out largest first.
module sm_sorter
  import sm_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned M = M_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [N-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [N-1:0] o_data,
  input  logic         i_ready,
  output logic         o_busy
);

  localparam int unsigned CW       = idx_width(M);
  localparam logic [CW-1:0] LAST   = CW'(M - 1);
  localparam logic [CW-1:0] LAST_J = CW'(M - 2);

  sm_state_t     state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] j_q, j_d;
  logic [CW-1:0] p_q, p_d;
  logic [N-1:0]  r_q [M];
  logic [N-1:0]  r_d [M];

  logic [N-1:0]  cmp_a;
  logic [N-1:0]  cmp_b;
  logic          cmp_ge;
  logic          in_fire;
  logic          out_fire;

  // Shared comparator operands: adjacent pair selected by j.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    for (int unsigned i = 0; i < M - 1; i++) begin
      if (j_q == CW'(i)) begin
        cmp_a = r_q[i];
        cmp_b = r_q[i+1];
      end
    end
  end

  comparator #(.N(N)) u_cmp (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .ge_o (cmp_ge)
  );

  // Outputs depend only on registered state, never on i_valid or i_ready.
  always_comb begin
    o_ready = (state_q == LOAD);
    o_valid = (state_q == OUT);
    o_busy  = (state_q == SORT);
    o_data  = '0;
    if (state_q == OUT) begin
      for (int unsigned i = 0; i < M; i++) begin
        if (k_q == CW'(i)) o_data = r_q[i];
      end
    end
  end

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    p_d     = p_q;
    r_d     = r_q;
    case (state_q)
      LOAD: begin
        if (in_fire) begin
          for (int unsigned i = 0; i < M; i++) begin
            if (k_q == CW'(i)) r_d[i] = i_data;
          end
          if (k_q == LAST) begin
            k_d     = '0;
            j_d     = '0;
            p_d     = '0;
            state_d = SORT;
          end else begin
            k_d = k_q + CW'(1);
          end
        end
      end
      SORT: begin
        // Swap only on strict a < b so equal encodings keep their order.
        if (!cmp_ge) begin
          for (int unsigned i = 0; i < M - 1; i++) begin
            if (j_q == CW'(i)) begin
              r_d[i]   = r_q[i+1];
              r_d[i+1] = r_q[i];
            end
          end
        end
        if (j_q == LAST_J) begin
          j_d = '0;
          if (p_q == LAST_J) begin
            p_d     = '0;
            state_d = OUT;
          end else begin
            p_d = p_q + CW'(1);
          end
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      OUT: begin
        if (out_fire) begin
          if (k_q == LAST) begin
            k_d     = '0;
            state_d = LOAD;
          end else begin
            k_d = k_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
        k_d     = '0;
        j_d     = '0;
        p_d     = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= LOAD;
      k_q     <= '0;
      j_q     <= '0;
      p_q     <= '0;
      for (int unsigned i = 0; i < M; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      p_q     <= p_d;
      r_q     <= r_d;
    end
  end

endmodule

// File: tb/tb_sm_sorter.sv
// Self-checking bench for sm_sorter (M=4/N=8 and M=2/N=4 instances) against
// a key-based insertion-sort reference model.
module tb_sm_sorter;

  logic       clk = 1'b0;
  logic       rst;

  logic       valid;
  logic [7:0] din;
  logic       ready_o;
  logic       ovalid;
  logic [7:0] dout;
  logic       iready;
  logic       busy;

  logic       valid2;
  logic [3:0] din2;
  logic       ready2;
  logic       ovalid2;
  logic [3:0] dout2;
  logic       iready2;
  logic       busy2;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] batch [4];
  logic [7:0] exp2  [4];

  always #5 clk = ~clk;

  sm_sorter #(.N(8), .M(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_data  (din),
    .o_ready (ready_o),
    .o_valid (ovalid),
    .o_data  (dout),
    .i_ready (iready),
    .o_busy  (busy)
  );

  sm_sorter #(.N(4), .M(2)) dut2 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid2),
    .i_data  (din2),
    .o_ready (ready2),
    .o_valid (ovalid2),
    .o_data  (dout2),
    .i_ready (iready2),
    .o_busy  (busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Numeric rank of a sign-magnitude value; +0 sits just above -0.
  function automatic int rank(input logic [7:0] x, input int nb);
    int mag;
    mag = int'(x) & ((1 << (nb - 1)) - 1);
    if (x[nb-1]) return -(2 * mag + 1);
    return 2 * mag;
  endfunction

  // Stable descending insertion sort of the first n_el entries.
  task automatic model_sort(input logic [7:0] d [4], input int n_el, input int nb,
                            output logic [7:0] e [4]);
    logic [7:0] tmp;
    int jj;
    e = d;
    for (int i = 1; i < n_el; i++) begin
      jj = i;
      while (jj > 0 && rank(e[jj], nb) > rank(e[jj-1], nb)) begin
        tmp     = e[jj];
        e[jj]   = e[jj-1];
        e[jj-1] = tmp;
        jj--;
      end
    end
  endtask

  function automatic logic [7:0] rnd_val(input int nb);
    logic [7:0] sgn;
    logic [7:0] mask;
    sgn  = 8'(1 << (nb - 1));
    mask = 8'((1 << nb) - 1);
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return sgn;
      2:       return sgn | 8'h01;
      default: return 8'($urandom) & mask;
    endcase
  endfunction

  task automatic load_only(input logic [7:0] d [4], input bit gap);
    for (int i = 0; i < 4; i++) begin
      if (gap) begin
        valid = 1'b0;
        din   = 8'($urandom);
        check("gap_ready", 32'(ready_o), 32'd1);
        @(posedge clk); #1;
      end
      valid = 1'b1;
      din   = d[i];
      check("load_ready", 32'(ready_o), 32'd1);
      @(posedge clk); #1;
    end
    valid = 1'b0;
  endtask

  task automatic run_batch(input logic [7:0] d [4], input bit gap, input int stall_at,
                           input bit poke);
    logic [7:0] e [4];
    int cyc;
    int busy_cyc;
    model_sort(d, 4, 8, e);
    load_only(d, gap);
    cyc      = 0;
    busy_cyc = 0;
    while (ovalid !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1 && ready_o === 1'b0) busy_cyc++;
      if (poke) begin
        valid = 1'b1;
        din   = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    valid = 1'b0;
    check("sort_latency", 32'(cyc), 32'd9);
    check("busy_cycles", 32'(busy_cyc), 32'd9);
    check("busy_in_out", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        iready = 1'b0;
        repeat (3) begin
          check("stall_valid", 32'(ovalid), 32'd1);
          check("stall_data", 32'(dout), 32'(e[i]));
          @(posedge clk); #1;
        end
      end
      iready = 1'b1;
      check("out_valid", 32'(ovalid), 32'd1);
      check("out_data", 32'(dout), 32'(e[i]));
      @(posedge clk); #1;
    end
    iready = 1'b0;
    check("done_valid", 32'(ovalid), 32'd0);
    check("done_ready", 32'(ready_o), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst     = 1'b0;
    valid   = 1'b0;
    din     = '0;
    iready  = 1'b0;
    valid2  = 1'b0;
    din2    = '0;
    iready2 = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(ovalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(dout), 32'd0);
    check("rst_ready2", 32'(ready2), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    batch = '{8'h05, 8'h85, 8'h7F, 8'h00};
    run_batch(batch, 1'b0, -1, 1'b0);
    batch = '{8'h80, 8'h00, 8'h81, 8'h01};
    run_batch(batch, 1'b0, -1, 1'b0);
    batch = '{8'h83, 8'h83, 8'h83, 8'h83};
    run_batch(batch, 1'b0, -1, 1'b0);

    for (int i = 0; i < 4; i++) batch[i] = rnd_val(8);
    run_batch(batch, 1'b1, -1, 1'b0);
    for (int i = 0; i < 4; i++) batch[i] = rnd_val(8);
    run_batch(batch, 1'b0, 1, 1'b0);
    for (int i = 0; i < 4; i++) batch[i] = rnd_val(8);
    run_batch(batch, 1'b0, -1, 1'b1);

    // Reset four cycles into SORT.
    batch = '{8'h11, 8'h92, 8'h33, 8'hC4};
    load_only(batch, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready_o), 32'd1);
    check("mid_rst_valid", 32'(ovalid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(dout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    batch = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_batch(batch, 1'b0, -1, 1'b0);

    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 4; i++) batch[i] = rnd_val(8);
      run_batch(batch, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)));
    end

    // M=2, N=4: back-to-back batches with the consumer always ready.
    iready2 = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (b == 0) begin
        batch[0] = 8'h09;
        batch[1] = 8'h01;
      end else begin
        batch[0] = rnd_val(4);
        batch[1] = rnd_val(4);
      end
      batch[2] = 8'h00;
      batch[3] = 8'h00;
      model_sort(batch, 2, 4, exp2);
      for (int i = 0; i < 2; i++) begin
        valid2 = 1'b1;
        din2   = batch[i][3:0];
        check("m2_ready", 32'(ready2), 32'd1);
        @(posedge clk); #1;
      end
      valid2 = 1'b0;
      check("m2_busy", 32'(busy2), 32'd1);
      check("m2_sort_valid", 32'(ovalid2), 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        check("m2_out_valid", 32'(ovalid2), 32'd1);
        check("m2_out_data", 32'(dout2), 32'(exp2[i]));
        @(posedge clk); #1;
      end
    end
    iready2 = 1'b0;
    check("m2_idle_valid", 32'(ovalid2), 32'd0);
    check("m2_idle_ready", 32'(ready2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
